// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: tree-PLRU replacement, multi-beat refill, flush.
// Define ICACHE_PERF_CNT_EN to add saturating hit_cnt_o / miss_cnt_o counters.
module icache_assoc #(
    parameter int ADDRESS_SIZE  = 40,
    parameter int I_WORD_SIZE   = 32,
    parameter int N_WORDS_BLOCK = 4,
    parameter int CACHE_SIZE    = 4096,
    parameter int N_WAYS        = 2,
    parameter int MEM_BUS       = 64,
    localparam int LINE         = I_WORD_SIZE * N_WORDS_BLOCK
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDRESS_SIZE-1:0] addr_i,
    input  logic                    strobe_i,
    input  logic                    uncached_i,
    input  logic                    flush_i,
    input  logic [MEM_BUS-1:0]      mdout_i,
    input  logic                    m_ready_i,
    output logic [LINE-1:0]         p_din_o,
    output logic                    p_ready_o,
    output logic                    cache_miss_o,
    output logic [ADDRESS_SIZE-1:0] m_a_o,
    output logic                    m_strobe_o,
    output logic                    busy_o
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
`endif
);
    localparam int N_SETS = CACHE_SIZE / (LINE * N_WAYS);
    localparam int BEATS  = LINE / MEM_BUS;
    localparam int OFF    = $clog2(LINE / 8);
    localparam int IDX_W  = $clog2(N_SETS);
    localparam int TAG_W  = ADDRESS_SIZE - OFF - IDX_W;
    localparam int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
    localparam int LVL    = (N_WAYS > 1) ? $clog2(N_WAYS) : 0;
    localparam int PLRU_W = (N_WAYS > 1) ? N_WAYS - 1 : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [N_SETS-1:0]       valid_reg [N_WAYS];
    logic [PLRU_W-1:0]       plru_reg  [N_SETS];
    logic [TAG_W-1:0]        tag_mem   [N_WAYS][N_SETS];
    logic [LINE-1:0]         data_mem  [N_WAYS][N_SETS];
    logic [BEAT_W-1:0]       beat_reg;
    logic [ADDRESS_SIZE-1:0] base_reg;
    logic                    uncached_reg;
    logic [WAY_W-1:0]        victim_reg;
    logic [LINE-1:0]         line_buf_reg;
    logic                    flush_pending_reg;

    logic [IDX_W-1:0]        lk_idx, fill_idx;
    logic [TAG_W-1:0]        lk_tag, fill_tag;
    logic [N_WAYS-1:0]       way_hit;
    logic [LINE-1:0]         way_line [N_WAYS];
    logic                    any_hit;
    logic [WAY_W-1:0]        hit_way, victim_next;
    logic [LINE-1:0]         hit_line, fill_line;
    logic                    lookup_ok, hit_evt, refill_start, last_beat, fill_we;

    // Tree walk: a node bit of 0 sends the victim search to the lower-index subtree.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int node;
        node = 0;
        for (int l = 0; l < LVL; l++)
            node = 2 * node + 1 + int'(bits[node]);
        return WAY_W'(node - (N_WAYS - 1));
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        logic              dir;
        int                node;
        r    = bits;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            dir     = way[LVL-1-l];
            r[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction

    assign lk_idx   = addr_i[OFF+IDX_W-1:OFF];
    assign lk_tag   = addr_i[ADDRESS_SIZE-1:OFF+IDX_W];
    assign fill_idx = base_reg[OFF+IDX_W-1:OFF];
    assign fill_tag = base_reg[ADDRESS_SIZE-1:OFF+IDX_W];

    generate
        for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_way
            assign way_hit[gi]  = valid_reg[gi][lk_idx] && (tag_mem[gi][lk_idx] == lk_tag);
            assign way_line[gi] = way_hit[gi] ? data_mem[gi][lk_idx] : '0;
        end
    endgenerate

    always_comb begin
        any_hit     = |way_hit;
        hit_way     = '0;
        hit_line    = '0;
        victim_next = plru_victim(plru_reg[lk_idx]);
        // Descending scan leaves the lowest matching index selected.
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (way_hit[w])
                hit_way = WAY_W'(w);
            if (!valid_reg[w][lk_idx])
                victim_next = WAY_W'(w);
        end
        for (int w = 0; w < N_WAYS; w++)
            hit_line = hit_line | way_line[w];
    end

    assign lookup_ok    = (state_reg == IDLE) && strobe_i && !flush_i && !flush_pending_reg;
    assign hit_evt      = lookup_ok && any_hit;
    assign refill_start = lookup_ok && !any_hit;
    assign last_beat    = (state_reg == REFILL) && m_ready_i && (beat_reg == BEAT_W'(BEATS - 1));
    assign fill_we      = last_beat && !uncached_reg;

    always_comb begin
        fill_line = line_buf_reg;
        fill_line[int'(beat_reg) * MEM_BUS +: MEM_BUS] = mdout_i;
    end

    always_comb begin
        state_next   = state_reg;
        p_ready_o    = 1'b0;
        p_din_o      = '0;
        cache_miss_o = 1'b0;
        m_a_o        = '0;
        m_strobe_o   = 1'b0;
        busy_o       = 1'b0;
        case (state_reg)
            IDLE:    if (refill_start) state_next = REFILL;
            REFILL:  if (last_beat) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Outputs are forced low for the whole time reset is held.
        if (!rst_i) begin
            case (state_reg)
                IDLE: begin
                    m_a_o = addr_i;
                    if (strobe_i) begin
                        if (hit_evt) begin
                            p_ready_o = 1'b1;
                            p_din_o   = hit_line;
                        end else begin
                            cache_miss_o = 1'b1;
                        end
                    end
                end
                REFILL: begin
                    busy_o       = 1'b1;
                    m_strobe_o   = 1'b1;
                    cache_miss_o = 1'b1;
                    m_a_o        = base_reg + ADDRESS_SIZE'(beat_reg) * ADDRESS_SIZE'(MEM_BUS / 8);
                end
                RESP: begin
                    busy_o    = 1'b1;
                    p_ready_o = 1'b1;
                    p_din_o   = line_buf_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg         <= IDLE;
            beat_reg          <= '0;
            base_reg          <= '0;
            uncached_reg      <= 1'b0;
            victim_reg        <= '0;
            line_buf_reg      <= '0;
            flush_pending_reg <= 1'b0;
            for (int w = 0; w < N_WAYS; w++)
                valid_reg[w] <= '0;
            for (int s = 0; s < N_SETS; s++)
                plru_reg[s] <= '0;
        end else begin
            state_reg <= state_next;
            if (refill_start) begin
                base_reg     <= {addr_i[ADDRESS_SIZE-1:OFF], OFF'(0)};
                uncached_reg <= uncached_i;
                victim_reg   <= victim_next;
                beat_reg     <= '0;
            end
            if (state_reg == REFILL && m_ready_i) begin
                line_buf_reg <= fill_line;
                beat_reg     <= last_beat ? '0 : beat_reg + 1'b1;
            end
            if (fill_we) begin
                valid_reg[victim_reg][fill_idx] <= 1'b1;
                if (N_WAYS > 1)
                    plru_reg[fill_idx] <= plru_touch(plru_reg[fill_idx], victim_reg);
            end
            if (hit_evt && N_WAYS > 1)
                plru_reg[lk_idx] <= plru_touch(plru_reg[lk_idx], hit_way);
            // A flush seen while busy is held until the first IDLE cycle, after the fill write.
            if (state_reg == IDLE && (flush_i || flush_pending_reg)) begin
                flush_pending_reg <= 1'b0;
                for (int w = 0; w < N_WAYS; w++)
                    valid_reg[w] <= '0;
                for (int s = 0; s < N_SETS; s++)
                    plru_reg[s] <= '0;
            end else if (state_reg != IDLE && flush_i) begin
                flush_pending_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_mem[victim_reg][fill_idx]  <= fill_tag;
            data_mem[victim_reg][fill_idx] <= fill_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (flush_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit_evt && hit_cnt_o != 32'hFFFF_FFFF)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (refill_start && miss_cnt_o != 32'hFFFF_FFFF)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: directed fetches push expected lines, a monitor checks responses.
module tb_icache_assoc;
    localparam int AW = 40;
    localparam int LW = 128;
    localparam int MB = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] addr_i;
    logic          strobe_i;
    logic          uncached_i;
    logic          flush_i;
    logic [MB-1:0] mdout_i;
    logic          m_ready_i;
    logic [LW-1:0] p_din_o;
    logic          p_ready_o;
    logic          cache_miss_o;
    logic [AW-1:0] m_a_o;
    logic          m_strobe_o;
    logic          busy_o;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    icache_assoc dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .addr_i       (addr_i),
        .strobe_i     (strobe_i),
        .uncached_i   (uncached_i),
        .flush_i      (flush_i),
        .mdout_i      (mdout_i),
        .m_ready_i    (m_ready_i),
        .p_din_o      (p_din_o),
        .p_ready_o    (p_ready_o),
        .cache_miss_o (cache_miss_o),
        .m_a_o        (m_a_o),
        .m_strobe_o   (m_strobe_o),
        .busy_o       (busy_o)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int            tests = 0;
    int            fails = 0;
    logic [LW-1:0] exp_q [$];

    // Memory image: each 8-byte beat carries its own address between fixed markers.
    function automatic logic [MB-1:0] mem_beat(input logic [AW-1:0] a);
        return {8'hA5, a, 16'h5A5A};
    endfunction

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] base);
        return {mem_beat(base + 40'd8), mem_beat(base)};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every p_ready_o cycle consumes one expected line.
    initial begin
        logic [LW-1:0] exp_line;
        forever begin
            @(negedge clk_i);
            if (p_ready_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: got %h expected no response", p_din_o);
                end else begin
                    exp_line = exp_q.pop_front();
                    check("resp_line", p_din_o, exp_line);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fetch(input logic [AW-1:0] a, input logic unc, input logic exp_hit,
                         input int stall, input logic flush_mid);
        logic [AW-1:0] base;
        base = {a[AW-1:4], 4'h0};
        $display("[TB] fetch addr=%h uncached=%0b expect=%s stall=%0d flush=%0b",
                 a, unc, exp_hit ? "hit" : "miss", stall, flush_mid);
        tick();
        addr_i     = a;
        strobe_i   = 1'b1;
        uncached_i = unc;
        exp_q.push_back(mem_line(base));
        @(negedge clk_i);
        check("miss_flag", cache_miss_o, !exp_hit);
        tick();
        strobe_i   = 1'b0;
        uncached_i = 1'b0;
        addr_i     = '0;
        if (!exp_hit) begin
            for (int b = 0; b < 2; b++) begin
                if (b == 1) begin
                    m_ready_i = 1'b0;
                    for (int s = 0; s < stall; s++) begin
                        @(negedge clk_i);
                        check("stall_hold", {m_strobe_o, p_ready_o, m_a_o}, {1'b1, 1'b0, base + 40'd8});
                        tick();
                    end
                end
                m_ready_i = 1'b1;
                mdout_i   = mem_beat(base + 40'(b * 8));
                if (b == 0)
                    flush_i = flush_mid;
                @(negedge clk_i);
                check("beat_addr", {m_strobe_o, m_a_o}, {1'b1, base + 40'(b * 8)});
                tick();
                m_ready_i = 1'b0;
                flush_i   = 1'b0;
                mdout_i   = '0;
            end
            @(negedge clk_i);
            check("resp_state", {busy_o, cache_miss_o, m_strobe_o}, 3'b100);
            tick();
        end
        tick();
    endtask

    initial begin
        rst_i      = 1'b1;
        addr_i     = 40'h123;
        strobe_i   = 1'b1;
        uncached_i = 1'b0;
        flush_i    = 1'b0;
        mdout_i    = '0;
        m_ready_i  = 1'b0;
        #2;
        check("reset_outputs", {p_ready_o, cache_miss_o, m_strobe_o, busy_o, m_a_o}, '0);
        check("reset_pdin", p_din_o, '0);
        strobe_i = 1'b0;
        addr_i   = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Cold miss then same-line hit
        fetch(40'h100, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h104, 1'b0, 1'b1, 0, 1'b0);
        // Set 0 associativity and PLRU eviction
        fetch(40'h000, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h400, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h000, 1'b0, 1'b1, 0, 1'b0);
        fetch(40'h800, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h00C, 1'b0, 1'b1, 0, 1'b0);
        fetch(40'h400, 1'b0, 1'b0, 0, 1'b0);
        // Uncached miss does not allocate
        fetch(40'h200, 1'b1, 1'b0, 0, 1'b0);
        fetch(40'h200, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h208, 1'b0, 1'b1, 0, 1'b0);
        // Memory stall mid-refill
        fetch(40'h610, 1'b0, 1'b0, 10, 1'b0);
        fetch(40'h61C, 1'b0, 1'b1, 0, 1'b0);
        // Flush during refill invalidates everything including the new line
        fetch(40'h300, 1'b0, 1'b0, 0, 1'b1);
        fetch(40'h300, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h610, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h200, 1'b0, 1'b0, 0, 1'b0);

        // Async reset between beat 0 and beat 1
        $display("[TB] reset during refill of addr=%h", 40'h500);
        tick();
        addr_i   = 40'h500;
        strobe_i = 1'b1;
        @(negedge clk_i);
        check("rst_miss_flag", cache_miss_o, 1'b1);
        tick();
        strobe_i  = 1'b0;
        addr_i    = '0;
        m_ready_i = 1'b1;
        mdout_i   = mem_beat(40'h500);
        @(negedge clk_i);
        check("rst_beat0_addr", m_a_o, 40'h500);
        tick();
        m_ready_i = 1'b0;
        rst_i     = 1'b1;
        #1;
        check("rst_mid_outputs", {p_ready_o, cache_miss_o, m_strobe_o, busy_o, m_a_o}, '0);
        tick();
        rst_i = 1'b0;
        fetch(40'h500, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h300, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h504, 1'b0, 1'b1, 0, 1'b0);

        // Flush in IDLE: lookup reported as miss, no refill starts
        $display("[TB] flush in idle with fetch addr=%h", 40'h504);
        tick();
        addr_i   = 40'h504;
        strobe_i = 1'b1;
        flush_i  = 1'b1;
        @(negedge clk_i);
        check("flush_idle_miss", {cache_miss_o, p_ready_o}, 2'b10);
        tick();
        strobe_i = 1'b0;
        flush_i  = 1'b0;
        addr_i   = '0;
        @(negedge clk_i);
        check("flush_idle_norefill", {busy_o, m_strobe_o}, 2'b00);
        fetch(40'h500, 1'b0, 1'b0, 0, 1'b0);
        fetch(40'h30C, 1'b0, 1'b0, 0, 1'b0);

        tick();
        check("queue_drain", LW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache with a multi-beat refill state machine. Successor to the single-way direct-mapped icache.
- Sits between the fetch unit and the memory bus; returns a whole line per access.
- Adds over the direct-mapped generation: configurable associativity, pseudo-LRU replacement, refill over a bus narrower than the line, and a flush.

Parameters:
ADDRESS_SIZE, 40, address width in bits
I_WORD_SIZE, 32, instruction word width
N_WORDS_BLOCK, 4, words per line (power of 2)
CACHE_SIZE, 4096, total data bits (power of 2)
N_WAYS, 2, associativity (power of 2, 1..8)
MEM_BUS, 64, memory data width; LINE = I_WORD_SIZE*N_WORDS_BLOCK must be a multiple of MEM_BUS

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
addr_i  in  ADDRESS_SIZE  fetch byte address
strobe_i  in  1  fetch request
uncached_i  in  1  1 = do not allocate the fetched line
flush_i  in  1  invalidate all lines
mdout_i  in  MEM_BUS  refill beat data
m_ready_i  in  1  beat valid from memory
p_din_o  out  LINE  line returned to the CPU
p_ready_o  out  1  p_din_o valid this cycle
cache_miss_o  out  1  lookup missed (IDLE) or refill in progress
m_a_o  out  ADDRESS_SIZE  beat address
m_strobe_o  out  1  memory request
busy_o  out  1  state is not IDLE

Behaviour:
- Derived values:
  - N_SETS = CACHE_SIZE/(LINE*N_WAYS)
  - BEATS = LINE/MEM_BUS
  - OFF = log2(LINE/8) byte-offset bits
  - index = addr[OFF+log2(N_SETS)-1:OFF]
  - tag = remaining upper bits
- Storage:
  - valid, tag and data arrays per way/set.
  - Tag and valid are read combinationally.
  - PLRU is a tree of N_WAYS-1 bits per set; N_WAYS=1 means no PLRU.
- Reset (async, rst_i=1):
  - state=IDLE; all valid bits=0; PLRU=0; beat counter=0; flush_pending=0.
  - All outputs 0.
  - Reset mid-refill aborts the refill; m_strobe_o drops immediately.
- IDLE state:
  - Hit: strobe_i and a valid way whose tag matches gives p_ready_o=1 in the same cycle, p_din_o=that way's line, cache_miss_o=0, PLRU updated to point away from the hit way.
  - Miss:
    - cache_miss_o=1 combinationally and p_ready_o=0.
    - Capture the line-aligned address, uncached_i, and the victim way, then go to REFILL.
    - Victim selection: lowest-index invalid way; otherwise the PLRU-selected way.
- REFILL state:
  - m_strobe_o=1; m_a_o = captured line base + beat*(MEM_BUS/8).
  - Each cycle with m_ready_i=1, mdout_i goes into line buffer slice [beat] (beat 0 = LSBs) and the beat counter increments.
  - m_ready_i=0 stalls indefinitely with no timeout.
  - On the last beat (beat==BEATS-1 with m_ready_i):
    - Next cycle: state RESP.
    - If not uncached: write the buffered line into the victim way, set valid, write the tag, update PLRU.
    - If uncached: no array or PLRU change.
  - strobe_i and addr_i are ignored while busy_o=1.
- RESP state (one cycle):
  - p_ready_o=1; p_din_o = line buffer; m_strobe_o=0; cache_miss_o=0.
  - Next state IDLE.
  - Refill latency = BEATS memory cycles + 1 (RESP).
- Flush:
  - flush_i in IDLE clears all valid bits and PLRU at the next edge; the lookup that same cycle is reported as a miss and no refill starts.
  - flush_i during REFILL/RESP sets flush_pending.
  - The pending flush is applied on entry to IDLE, after the refill write, so the just-filled line is also invalidated.
  - A lookup in IDLE while flush_pending is set is not serviced that cycle.
- m_a_o = addr_i in IDLE (informational); m_strobe_o=0 in IDLE.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0].
  - hit_cnt_o increments on each IDLE hit; miss_cnt_o increments on each IDLE→REFILL transition.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are cleared by flush_i.
- Undefined: the ports and counters are absent, with no other difference.

Test Plan:
- Cold miss, defaults (BEATS=2): reset, strobe addr 0x100 → cache_miss_o=1, two beats at m_a_o 0x100/0x108, RESP p_din_o={beat1,beat0}; strobe 0x104 afterwards → same-cycle hit with the identical line.
- Associativity: fill three lines mapping to set 0 (addresses 0x000, 0x400, 0x800 for N_SETS=16, line 16B, way size 0x100 per set stride) with 0x000 re-hit before 0x800 → 0x400 evicted, 0x000 still hits, 0x400 misses.
- Uncached: uncached_i=1 on a miss at 0x200 → RESP delivers data; repeat strobe 0x200 → miss again, no array write.
- Stall: hold m_ready_i=0 for 10 cycles mid-refill → m_strobe_o stays 1, m_a_o stable, no p_ready_o.
- Flush: flush_i asserted during REFILL of 0x300 → RESP delivers the line, then 0x300 and all prior lines miss.
- Async reset: assert rst_i between beat 0 and beat 1 → outputs 0 immediately; a later strobe of the same address misses and refills from beat 0.
